spio_hss_multiplexer_stat_bank: RTL and testbench

//  Parametrised statistics/control register bank for the HSS multiplexer.
//  It replaces the fixed per-event counter set with NUM_CTRS generic event counters.
//  It also provides NUM_STAT live status words, a user control register,
//  per-counter enables, wrap/saturate mode, clear-on-read, an atomic snapshot
//  and sticky overflow flags with an interrupt.
//  It sits between the frame assembler/transmitter/disassembler/dispatcher

---
 rtl/spio_hss_multiplexer_stat_bank_if.sv | 21 ++
 rtl/spio_hss_multiplexer_stat_bank.sv | 145 ++++++++++++++
 tb/tb_spio_hss_multiplexer_stat_bank.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spio_hss_multiplexer_stat_bank_if.sv
// Host register access bus for the HSS multiplexer statistics bank.
interface spio_hss_multiplexer_stat_bank_if #(
  parameter int unsigned REGA_BITS = 6,
  parameter int unsigned REGD_BITS = 32
);
  logic                 reg_write;
  logic                 reg_read;
  logic [REGA_BITS-1:0] reg_addr;
  logic [REGD_BITS-1:0] reg_write_data;
  logic [REGD_BITS-1:0] reg_read_data;

  modport master (
    output reg_write, reg_read, reg_addr, reg_write_data,
    input  reg_read_data
  );

  modport slave (
    input  reg_write, reg_read, reg_addr, reg_write_data,
    output reg_read_data
  );
endinterface

// File: rtl/spio_hss_multiplexer_stat_bank.sv
// Statistics/control register bank for the HSS multiplexer: generic event
// counters with enable/mask/freeze, wrap or saturate, clear-on-read, shadow
// snapshot, sticky overflow flags with interrupt, status words and a user
// control register behind a registered-read host interface.
module spio_hss_multiplexer_stat_bank #(
  parameter int unsigned NUM_CTRS  = 16,
  parameter int unsigned CTR_BITS  = 32,
  parameter int unsigned NUM_STAT  = 8,
  parameter int unsigned REGA_BITS = 6,
  parameter int unsigned REGD_BITS = 32,
  parameter int unsigned SATURATE  = 1,
  parameter logic [31:0] VERSION   = 32'h0002_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CTRS-1:0]           evt_inc,
  input  logic [NUM_STAT*REGD_BITS-1:0] stat_in,
  output logic [REGD_BITS-1:0]          ctl_out,
  output logic                          ovf_irq,
  spio_hss_multiplexer_stat_bank_if.slave host
);

  logic [CTR_BITS-1:0]  ctr_q    [NUM_CTRS];
  logic [CTR_BITS-1:0]  ctr_d    [NUM_CTRS];
  logic [CTR_BITS-1:0]  shadow_q [NUM_CTRS];
  logic [CTR_BITS-1:0]  shadow_d [NUM_CTRS];
  logic [3:0]           ctrl_q, ctrl_d;
  logic [NUM_CTRS-1:0]  mask_q, mask_d;
  logic [NUM_CTRS-1:0]  ovf_q, ovf_d;
  logic [NUM_CTRS-1:0]  ovf_msk_q, ovf_msk_d;
  logic [REGD_BITS-1:0] ctl_q, ctl_d;
  logic [REGD_BITS-1:0] rd_q, rd_d;
  logic                 irq_q, irq_d;

  logic [NUM_CTRS-1:0]  ovf_set;
  logic [NUM_CTRS-1:0]  ovf_clr;
  logic [CTR_BITS-1:0]  base;
  logic                 ctr_hit;
  logic                 cnt_en;

  function automatic logic wr_at(input int unsigned a);
    return host.reg_write && (host.reg_addr == REGA_BITS'(a));
  endfunction

  // Counter update: clear-on-read zeroes the base before a same-cycle event
  // is added, so no event is lost; a host write overrides both.
  always_comb begin
    ovf_set = '0;
    base    = '0;
    ctr_hit = 1'b0;
    cnt_en  = 1'b0;
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      cnt_en  = evt_inc[i] & ctrl_q[0] & mask_q[i] & ~ctrl_q[2];
      ctr_hit = (host.reg_addr == REGA_BITS'(16 + i));
      base    = (ctr_hit && host.reg_read && ctrl_q[1] && !ctrl_q[3]) ? '0 : ctr_q[i];
      ctr_d[i] = base;
      if (ctr_hit && host.reg_write) begin
        ctr_d[i] = host.reg_write_data[CTR_BITS-1:0];
      end else if (cnt_en) begin
        if (&base) begin
          ovf_set[i] = 1'b1;
          if (SATURATE == 0) ctr_d[i] = '0;
        end else begin
          ctr_d[i] = base + CTR_BITS'(1);
        end
      end
    end
  end

  // Control/status register writes, snapshot capture and overflow bookkeeping.
  always_comb begin
    ctrl_d    = ctrl_q;
    mask_d    = mask_q;
    ovf_msk_d = ovf_msk_q;
    ctl_d     = ctl_q;
    ovf_clr   = '0;
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      shadow_d[i] = wr_at(5) ? ctr_q[i] : shadow_q[i];
    end
    if (wr_at(1)) ctrl_d    = host.reg_write_data[3:0];
    if (wr_at(2)) mask_d    = host.reg_write_data[NUM_CTRS-1:0];
    if (wr_at(3)) ovf_clr   = host.reg_write_data[NUM_CTRS-1:0];
    if (wr_at(4)) ovf_msk_d = host.reg_write_data[NUM_CTRS-1:0];
    if (wr_at(6)) ctl_d     = host.reg_write_data;
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    irq_d = |(ovf_q & ovf_msk_q);
  end

  // Read data mux; unmapped addresses return all-ones.
  always_comb begin
    rd_d = '1;
    case (host.reg_addr)
      REGA_BITS'(0): rd_d = REGD_BITS'(VERSION);
      REGA_BITS'(1): rd_d = REGD_BITS'(ctrl_q);
      REGA_BITS'(2): rd_d = REGD_BITS'(mask_q);
      REGA_BITS'(3): rd_d = REGD_BITS'(ovf_q);
      REGA_BITS'(4): rd_d = REGD_BITS'(ovf_msk_q);
      REGA_BITS'(5): rd_d = '0;
      REGA_BITS'(6): rd_d = ctl_q;
      default:       ;
    endcase
    for (int unsigned i = 0; i < NUM_CTRS; i++) begin
      if (host.reg_addr == REGA_BITS'(16 + i))
        rd_d = REGD_BITS'(ctrl_q[3] ? shadow_q[i] : ctr_q[i]);
    end
    for (int unsigned k = 0; k < NUM_STAT; k++) begin
      if (host.reg_addr == REGA_BITS'(32 + k))
        rd_d = stat_in[k*REGD_BITS +: REGD_BITS];
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        ctr_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ctrl_q    <= 4'h1;
      mask_q    <= '1;
      ovf_q     <= '0;
      ovf_msk_q <= '0;
      ctl_q     <= '0;
      rd_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
        ctr_q[i]    <= ctr_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      ctrl_q    <= ctrl_d;
      mask_q    <= mask_d;
      ovf_q     <= ovf_d;
      ovf_msk_q <= ovf_msk_d;
      ctl_q     <= ctl_d;
      rd_q      <= rd_d;
      irq_q     <= irq_d;
    end
  end

  assign ctl_out            = ctl_q;
  assign ovf_irq            = irq_q;
  assign host.reg_read_data = rd_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_stat_bank.sv
// Scoreboard bench: two banks (saturating and wrapping) share one stimulus
// stream; a reference model predicts read data, ovf_irq and ctl_out.
module tb_spio_hss_multiplexer_stat_bank;

  logic         clk;
  logic         rst;
  logic [15:0]  evt;
  logic [255:0] stat;
  logic [255:0] stat_next;
  logic [31:0]  ctl0, ctl1;
  logic         irq0, irq1;

  spio_hss_multiplexer_stat_bank_if #(.REGA_BITS(6), .REGD_BITS(32)) bus0 ();
  spio_hss_multiplexer_stat_bank_if #(.REGA_BITS(6), .REGD_BITS(32)) bus1 ();

  spio_hss_multiplexer_stat_bank #(.SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .evt_inc(evt), .stat_in(stat),
    .ctl_out(ctl0), .ovf_irq(irq0), .host(bus0)
  );

  spio_hss_multiplexer_stat_bank #(.SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .evt_inc(evt), .stat_in(stat),
    .ctl_out(ctl1), .ovf_irq(irq1), .host(bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed { logic [31:0] r0; logic [31:0] r1; } rd_t;
  typedef struct packed { logic i0; logic i1; logic [31:0] c0; logic [31:0] c1; } st_t;

  rd_t q_rd[$];
  st_t q_st[$];
  bit  issue_rd;
  bit  issue_st;
  int  checks;
  int  failures;

  // Reference model state, index 0 = saturating bank, 1 = wrapping bank.
  logic [31:0] m_cnt [2][16];
  logic [31:0] m_shd [2][16];
  logic [3:0]  m_ctrl [2];
  logic [15:0] m_mask [2];
  logic [15:0] m_ovf  [2];
  logic [15:0] m_omsk [2];
  logic [31:0] m_ctl  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        m_cnt[d][i] = 32'h0;
        m_shd[d][i] = 32'h0;
      end
      m_ctrl[d] = 4'h1;
      m_mask[d] = 16'hFFFF;
      m_ovf[d]  = 16'h0;
      m_omsk[d] = 16'h0;
      m_ctl[d]  = 32'h0;
    end
  endtask

  function automatic logic [31:0] model_read(input int d, input logic [5:0] a);
    int ai;
    ai = int'(a);
    case (ai)
      0: return 32'h0002_0000;
      1: return {28'h0, m_ctrl[d]};
      2: return {16'h0, m_mask[d]};
      3: return {16'h0, m_ovf[d]};
      4: return {16'h0, m_omsk[d]};
      5: return 32'h0;
      6: return m_ctl[d];
      default: ;
    endcase
    if (ai >= 16 && ai < 32) return m_ctrl[d][3] ? m_shd[d][ai-16] : m_cnt[d][ai-16];
    if (ai >= 32 && ai < 40) return stat[(ai-32)*32 +: 32];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_step(input int d, input logic [15:0] e, input logic w, input logic r,
                            input logic [5:0] a, input logic [31:0] wd);
    logic [31:0] old [16];
    logic [32:0] v;
    logic [15:0] set, clr;
    int ai;
    ai = int'(a);
    set = 16'h0;
    clr = 16'h0;
    for (int i = 0; i < 16; i++) old[i] = m_cnt[d][i];
    for (int i = 0; i < 16; i++) begin
      if (w && ai == 16 + i) begin
        m_cnt[d][i] = wd;
      end else begin
        v = (r && m_ctrl[d][1] && !m_ctrl[d][3] && ai == 16 + i) ? 33'd0 : {1'b0, old[i]};
        if (e[i] && m_ctrl[d][0] && m_mask[d][i] && !m_ctrl[d][2]) begin
          v = v + 33'd1;
          if (v > 33'h0_FFFF_FFFF) begin
            set[i] = 1'b1;
            v = (d == 0) ? 33'h0_FFFF_FFFF : 33'd0;
          end
        end
        m_cnt[d][i] = v[31:0];
      end
    end
    if (w) begin
      case (ai)
        1: m_ctrl[d] = wd[3:0];
        2: m_mask[d] = wd[15:0];
        3: clr = wd[15:0];
        4: m_omsk[d] = wd[15:0];
        5: for (int i = 0; i < 16; i++) m_shd[d][i] = old[i];
        6: m_ctl[d] = wd;
        default: ;
      endcase
    end
    m_ovf[d] = (m_ovf[d] & ~clr) | set;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: every cycle the bench issued, compare DUT outputs with the queue head.
  initial begin
    rd_t r;
    st_t s;
    bit  v_rd, v_st;
    forever begin
      @(posedge clk);
      v_rd = issue_rd;
      v_st = issue_st;
      #2;
      if (v_st) begin
        if (q_st.size() == 0) check("st_underflow", 32'd0, 32'd1);
        else begin
          s = q_st.pop_front();
          check("irq_sat",  {31'h0, irq0}, {31'h0, s.i0});
          check("irq_wrap", {31'h0, irq1}, {31'h0, s.i1});
          check("ctl_sat",  ctl0, s.c0);
          check("ctl_wrap", ctl1, s.c1);
        end
      end
      if (v_rd) begin
        if (q_rd.size() == 0) check("rd_underflow", 32'd0, 32'd1);
        else begin
          r = q_rd.pop_front();
          check("rdata_sat",  bus0.reg_read_data, r.r0);
          check("rdata_wrap", bus1.reg_read_data, r.r1);
        end
      end
    end
  end

  // One bus cycle: drive at posedge+1, predict, then wait for the capturing edge.
  task automatic do_cycle(input logic [15:0] e, input logic w, input logic r, input logic [5:0] a,
                          input logic [31:0] wd, input bit chk, input bit ovr = 1'b0,
                          input logic [31:0] x0 = 32'h0, input logic [31:0] x1 = 32'h0);
    rd_t rr;
    st_t ss;
    #1;
    stat = stat_next;
    evt  = e;
    bus0.reg_write = w; bus0.reg_read = r; bus0.reg_addr = a; bus0.reg_write_data = wd;
    bus1.reg_write = w; bus1.reg_read = r; bus1.reg_addr = a; bus1.reg_write_data = wd;
    rr.r0 = ovr ? x0 : model_read(0, a);
    rr.r1 = ovr ? x1 : model_read(1, a);
    ss.i0 = |(m_ovf[0] & m_omsk[0]);
    ss.i1 = |(m_ovf[1] & m_omsk[1]);
    model_step(0, e, w, r, a, wd);
    model_step(1, e, w, r, a, wd);
    ss.c0 = m_ctl[0];
    ss.c1 = m_ctl[1];
    q_st.push_back(ss);
    if (chk) q_rd.push_back(rr);
    issue_st = 1'b1;
    issue_rd = chk;
    @(posedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    do_cycle(16'h0, 1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic rdx(input logic [5:0] a, input logic [31:0] x0, input logic [31:0] x1);
    do_cycle(16'h0, 1'b0, 1'b1, a, 32'h0, 1'b1, 1'b1, x0, x1);
  endtask

  task automatic pulse(input logic [15:0] e, input int n);
    for (int i = 0; i < n; i++) do_cycle(e, 1'b0, 1'b0, 6'h3F, 32'h0, 1'b0);
  endtask

  // Reset asserted mid-cycle, after the monitor has sampled the preceding edge.
  task automatic apply_reset();
    #1;
    issue_rd = 1'b0;
    issue_st = 1'b0;
    #4;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    evt = 16'h0;
    bus0.reg_write = 1'b0; bus0.reg_read = 1'b0;
    bus1.reg_write = 1'b0; bus1.reg_read = 1'b0;
    rst = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  a;
    logic [31:0] d;
    int          op;
    checks = 0;
    failures = 0;
    issue_rd = 1'b0;
    issue_st = 1'b0;
    rst = 1'b1;
    evt = 16'h0;
    for (int k = 0; k < 8; k++) stat_next[k*32 +: 32] = $urandom;
    stat = stat_next;
    bus0.reg_write = 1'b0; bus0.reg_read = 1'b0; bus0.reg_addr = '0; bus0.reg_write_data = '0;
    bus1.reg_write = 1'b0; bus1.reg_read = 1'b0; bus1.reg_addr = '0; bus1.reg_write_data = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);

    // Reset values and unmapped read.
    rdx(6'h00, 32'h0002_0000, 32'h0002_0000);
    rdx(6'h01, 32'h1, 32'h1);
    rdx(6'h02, 32'hFFFF, 32'hFFFF);
    rdx(6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rdx(6'h10, 32'h0, 32'h0);

    // Counting and masking.
    pulse(16'h0008, 5);
    rdx(6'h13, 32'd5, 32'd5);
    wr(6'h02, 32'hFFF7);
    pulse(16'h0008, 3);
    rdx(6'h13, 32'd5, 32'd5);
    wr(6'h02, 32'hFFFF);

    // Overflow: saturate vs wrap, sticky flag, interrupt, W1C.
    wr(6'h14, 32'hFFFF_FFFE);
    pulse(16'h0010, 3);
    rdx(6'h14, 32'hFFFF_FFFF, 32'h1);
    rdx(6'h03, 32'h10, 32'h10);
    wr(6'h04, 32'h10);
    pulse(16'h0, 2);
    wr(6'h03, 32'h10);
    rdx(6'h03, 32'h0, 32'h0);
    pulse(16'h0, 2);

    // Clear-on-read with a same-cycle event.
    wr(6'h01, 32'h3);
    wr(6'h10, 32'd7);
    do_cycle(16'h0001, 1'b0, 1'b1, 6'h10, 32'h0, 1'b1, 1'b1, 32'd7, 32'd7);
    rdx(6'h10, 32'd1, 32'd1);
    wr(6'h01, 32'h1);

    // Snapshot and shadow select.
    wr(6'h12, 32'd9);
    wr(6'h05, 32'h0);
    wr(6'h01, 32'h9);
    pulse(16'h0004, 4);
    rdx(6'h12, 32'd9, 32'd9);
    wr(6'h01, 32'h1);
    rdx(6'h12, 32'd13, 32'd13);

    // Reset in the middle of counting.
    wr(6'h06, 32'hA5A5_5A5A);
    pulse(16'h0002, 3);
    apply_reset();
    for (int i = 0; i < 16; i++) rdx(6'(16 + i), 32'h0, 32'h0);
    rdx(6'h06, 32'h0, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      op = $urandom_range(0, 9);
      a  = 6'($urandom_range(0, 63));
      d  = $urandom;
      case (op)
        0, 1:    do_cycle(16'($urandom), 1'b0, 1'b1, 6'(16 + $urandom_range(0, 15)), 32'h0, 1'b1);
        2, 3:    do_cycle(16'($urandom), 1'b0, 1'($urandom_range(0, 1)), a, 32'h0, 1'b1);
        4:       do_cycle(16'($urandom), 1'b1, 1'b0, 6'h01, {28'h0, 4'($urandom_range(0, 15))}, 1'b0);
        5:       do_cycle(16'($urandom), 1'b1, 1'b0, 6'(16 + $urandom_range(0, 15)),
                          32'hFFFF_FFFF - 32'($urandom_range(0, 3)), 1'b0);
        6:       do_cycle(16'($urandom), 1'b1, 1'b0, 6'($urandom_range(2, 6)), d, 1'b0);
        7:       do_cycle(16'($urandom), 1'b0, 1'b0, a, 32'h0, 1'b0);
        8:       do_cycle(16'($urandom), 1'b1, 1'b0, a, d, 1'b0);
        default: begin
          stat_next[$urandom_range(0, 7)*32 +: 32] = $urandom;
          do_cycle(16'($urandom), 1'b0, 1'b0, 6'(32 + $urandom_range(0, 7)), 32'h0, 1'b1);
        end
      endcase
    end

    #1;
    issue_rd = 1'b0;
    issue_st = 1'b0;
    bus0.reg_write = 1'b0; bus1.reg_write = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (q_rd.size() != 0 || q_st.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q_rd.size() + q_st.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
